// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit full adder built from two half-adder cells and an OR.
// half_adder is the gate-level cell whose sum/carry behaviour the serial
// adder uses as its per-bit datapath.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    // First cell adds the operand bits, second folds in the carry.
    half_adder u_ha0 (
        .i_a (i_a),
        .i_b (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder u_ha1 (
        .i_a (w_s0),
        .i_b (i_c),
        .o_s (o_s),
        .o_c (w_c1)
    );

    // Both half-adder carries can never be high together, so OR gives majority.
    assign o_c = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder of two WIDTH-bit operands.
// One full-adder stage plus a carry flip-flop iterated over WIDTH cycles,
// with a start/done handshake. Result and carry-out are registered and
// only change when an operation completes.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port that turns the
// operation into a - b (two's complement; cout=1 means no borrow).

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_last;
    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_res_final;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_init;

    // A request is only taken when no operation is in flight.
    assign w_load = start && (r_state != RUN);
    assign w_last = (r_state == RUN) && (r_cnt == LAST_CNT);

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction: add the inverted B with an initial carry of one.
    assign w_b_load = sub ? ~b : b;
    assign w_c_init = sub;
`else
    assign w_b_load = b;
    assign w_c_init = 1'b0;
`endif

    full_adder u_fa (
        .i_a (r_a_sr[0]),
        .i_b (r_b_sr[0]),
        .i_c (r_c),
        .o_s (w_fa_s),
        .o_c (w_fa_c)
    );

    // Result including the bit produced on this edge, used on the final edge.
    assign w_res_final = {w_fa_s, {(WIDTH-1){1'b0}}} | (r_res_sr >> 1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: DONE can reload directly so back-to-back has no bubble.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded purely from state, so no input-to-output path exists.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, carry FF, partial result and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a_sr   <= a;
            r_b_sr   <= w_b_load;
            r_res_sr <= '0;
            r_c      <= w_c_init;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_final;
            r_c      <= w_fa_c;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Visible result: updated only when an operation completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (w_last) begin
            sum  <= w_res_final;
            cout <= w_fa_c;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector scoreboard bench for serial_adder (WIDTH=8).
// Expected {cout,sum} values are pushed when a request is issued; a monitor
// pops and compares whenever done is seen. Sequence checks cover reset,
// latency, busy length, result stability, ignored start, mid-run reset and
// back-to-back operation. Define SERIAL_ADDER_SUB_EN to add subtract vectors.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       sub = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got sum=%0h cout=%0b expected no result", sum, cout);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {55'd0, cout, sum}, {55'd0, mon_e});
            end
        end
    end

    // Issue one request; start is left high when hold is set.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                         input logic [7:0] es, input logic ec, input bit push, input bit hold);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        if (push) exp_q.push_back({ec, es});
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Wait for done after an accept, checking latency, busy length and that
    // sum/cout hold their previous value while running. Optionally pulses
    // start (with different operands) at RUN cycle inject_at.
    task automatic wait_done(input int exp_lat, input logic [7:0] prev_s, input logic prev_c,
                             input int inject_at);
        int  nb = 0;
        int  lat = 0;
        bit  stable = 1'b1;
        bit  seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == inject_at) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (k == inject_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat = k;
                break;
            end
            if (busy) begin
                nb++;
                if (sum !== prev_s || cout !== prev_c) stable = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("latency", 64'(lat), 64'(exp_lat));
            check("busy_cycles", 64'(nb), 64'd8);
            check("sum_stable_run", 64'(stable), 64'd1);
        end
    endtask

    logic [7:0] bb_a[4] = '{8'h01, 8'hFF, 8'h12, 8'hC8};
    logic [7:0] bb_b[4] = '{8'h02, 8'hFF, 8'h34, 8'h64};
    logic [7:0] bb_s[4] = '{8'h03, 8'hFE, 8'h46, 8'h2C};
    logic       bb_c[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int ndone;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic additions
        issue(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1, 0);
        wait_done(9, 8'h00, 1'b0, -10);
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1, 0);
        wait_done(9, 8'h10, 1'b0, -10);
        issue(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1, 0);
        wait_done(9, 8'h00, 1'b1, -10);

        // start during RUN is ignored
        issue(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1, 0);
        wait_done(9, 8'hFF, 1'b0, 3);
        @(negedge clk);
        check("after_ignored_idle", 64'(busy), 64'd0);

        // Reset mid-run discards the operation
        issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum", 64'(sum), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);

        // Back-to-back with start held high
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a = bb_a[i]; b = bb_b[i]; sub = 1'b0; start = 1'b1;
            exp_q.push_back({bb_c[i], bb_s[i]});
            @(posedge clk);
            #1;
            if (i > 0) check("b2b_no_bubble", 64'(busy), 64'd1);
            wait_done(9, (i == 0) ? 8'h00 : bb_s[i-1], (i == 0) ? 1'b0 : bb_c[i-1], -10);
        end
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle_after", 64'(busy), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // Subtraction
        issue(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1, 0);
        wait_done(9, 8'h2C, 1'b1, -10);
        issue(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1, 0);
        wait_done(9, 8'hFE, 1'b0, -10);
        issue(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, 1, 0);
        wait_done(9, 8'h02, 1'b1, -10);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
